// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM states, op encodings,
// and the overflow helper.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow of a two's-complement add: carry into MSB differs from carry out.
  function automatic logic signed_ovf(input logic c_msb_in, input logic c_out);
    return c_msb_in ^ c_out;
  endfunction

endpackage

// File: rtl/addsub_seq_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB so the
// top can derive signed overflow from the most significant chunk.
module addsub_seq_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  logic [CHUNK:0] c_s;

  // Bit-serial ripple through the chunk.
  always_comb begin
    c_s    = '0;
    s_o    = '0;
    c_s[0] = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
      c_s[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & c_s[i]) | (b_i[i] & c_s[i]);
    end
    cout_o     = c_s[CHUNK];
    c_msb_in_o = c_s[CHUNK-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract, CHUNK bits per clock, with registered result and C/V/N/Z flags.
// Optional feature: define ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] ch_a_s, ch_b_s, ch_s_s;
  logic             ch_cout_s, ch_cmsb_s;
  logic [WIDTH-1:0] fin_s;

  assign ch_a_s = a_q[k_q*CHUNK +: CHUNK];
  assign ch_b_s = b_q[k_q*CHUNK +: CHUNK];

  addsub_seq_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i        (ch_a_s),
    .b_i        (ch_b_s),
    .cin_i      (c_q),
    .s_o        (ch_s_s),
    .cout_o     (ch_cout_s),
    .c_msb_in_o (ch_cmsb_s)
  );

  // Next-state, datapath and flag computation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    c_d      = c_q;
    v_d      = v_q;
    done_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    fin_s    = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = (op == OP_SUB) ? ~b : b;
          c_d     = op;
          k_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d[k_q*CHUNK +: CHUNK] = ch_s_s;
        c_d = ch_cout_s;
        v_d = signed_ovf(ch_cmsb_s, ch_cout_s);
        if (k_q == KW'(N - 1)) begin
          state_d = ST_DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
`ifdef ADDSUB_SATURATE_EN
        // A wrapped-negative raw result means the true value overflowed upward.
        if (v_q) begin
          fin_s = acc_q[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          fin_s = acc_q;
        end
`else
        fin_s = acc_q;
`endif
        state_d  = ST_IDLE;
        done_d   = 1'b1;
        result_d = fin_s;
        carry_d  = c_q;
        ovf_d    = v_q;
        neg_d    = fin_s[WIDTH-1];
        zero_d   = (fin_s == '0);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      v_q      <= v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign negative = neg_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench: two instances (CHUNK=4 and CHUNK=16) share stimulus; expected
// results come from integer arithmetic and are checked when each instance pulses done.
module tb_addsub_seq;

  localparam int W   = 16;
  localparam int N4  = 4;
  localparam int N16 = 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;   // {C, V, N, Z}
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         busy4, done4, c4, v4, n4, z4;
  logic [W-1:0] res4;
  logic         busy16, done16, c16, v16, n16, z16;
  logic [W-1:0] res16;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q4[$];
  exp_t q16[$];

  addsub_seq #(.WIDTH(W), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy4), .done(done4), .result(res4), .carry(c4),
    .overflow(v4), .negative(n4), .zero(z4)
  );

  addsub_seq #(.WIDTH(W), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy16), .done(done16), .result(res16), .carry(c16),
    .overflow(v16), .negative(n16), .zero(z16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic exp_t model(input bit o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int sa, sb, tr, ua, ub, us;
    logic c, v;
    sa = $signed(av);
    sb = $signed(bv);
    ua = av;
    ub = bv;
    tr = o ? (sa - sb) : (sa + sb);
    us = o ? (ua - ub) : (ua + ub);
    e.res = us[W-1:0];
    c = o ? (ua >= ub) : (us > 65535);
    v = (tr > 32767) || (tr < -32768);
`ifdef ADDSUB_SATURATE_EN
    if (v) e.res = (tr > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.flags = {c, v, e.res[W-1], (e.res == 16'h0000)};
    e.cyc = 0;
    return e;
  endfunction

  // Monitor for the CHUNK=4 instance.
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("res_flags4", {12'd0, res4, c4, v4, n4, z4}, {12'd0, e.res, e.flags});
        check("latency4", cyc, e.cyc);
      end
    end
  end

  // Monitor for the CHUNK=16 instance.
  always @(negedge clk) begin
    if (!rst && done16) begin
      if (q16.size() == 0) begin
        check("unexpected_done16", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("res_flags16", {12'd0, res16, c16, v16, n16, z16}, {12'd0, e.res, e.flags});
        check("latency16", cyc, e.cyc);
      end
    end
  end

  task automatic run_op(input bit o, input logic [W-1:0] av, input logic [W-1:0] bv, input bit glitch);
    exp_t e;
    e = model(o, av, bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    e.cyc = cyc + N4 + 1;
    q4.push_back(e);
    e.cyc = cyc + N16 + 1;
    q16.push_back(e);
    @(negedge clk);
    start = 1'b0; op = ~o; a = W'($urandom); b = W'($urandom);
    check("busy_in_run", {31'd0, busy4}, 32'd1);
    if (glitch) begin
      @(posedge clk);
      #1;
      start = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 40 && (q4.size() != 0 || q16.size() != 0); i++) @(negedge clk);
    if (q4.size() != 0 || q16.size() != 0) begin
      check("done_timeout", 32'd1, 32'd0);
      q4.delete();
      q16.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outs4", {busy4, done4, c4, v4, n4, z4, res4}, 32'd0);
    check("reset_outs16", {busy16, done16, c16, v16, n16, z16, res16}, 32'd0);

    run_op(1'b1, 16'h0005, 16'h0003, 1'b0);
    run_op(1'b1, 16'h1234, 16'h1234, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0);
    run_op(1'b0, 16'h8000, 16'h8000, 1'b0);
    run_op(1'b1, 16'h0000, 16'h0001, 1'b0);
    run_op(1'b0, 16'h1111, 16'h2222, 1'b1);

    // Reset in the second RUN cycle: outputs clear at once and no done follows.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h7FFF; b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_run4", {busy4, done4, c4, v4, n4, z4, res4}, 32'd0);
    check("rst_mid_run16", {busy16, done16, c16, v16, n16, z16, res16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(1'b1, 16'h0005, 16'h0003, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
